div_share_arbiter: RTL and testbench



---
 rtl/div_share_arbiter_pkg.sv | 19 +
 rtl/div_share_arbiter_rr.sv | 32 +++
 rtl/div_share_arbiter.sv | 166 ++++++++++++++++
 tb/tb_div_share_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_share_arbiter_pkg.sv
// Shared types and constants for the divider-sharing arbiter and its round-robin picker.
package div_share_pkg;

  localparam int DIV_W = 32;
  localparam int MAX_ID_W = 4;
  localparam logic [DIV_W-1:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;

  // id is sized for the largest supported requester count; the top truncates it.
  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic [DIV_W-1:0]    quotient;
    logic [DIV_W-1:0]    remainder;
    logic                dbz;
    logic                err;
  } resp_t;

endpackage

// File: rtl/div_share_arbiter_rr.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping.
module rr_arbiter
  import div_share_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_req
);

  // Scan from the farthest offset down so the nearest one at/after ptr overwrites.
  always_comb begin : pick
    int cand;
    cand      = 0;
    grant     = '0;
    grant_idx = '0;
    any_req   = |req;
    for (int k = N - 1; k >= 0; k--) begin
      cand = (int'(ptr) + k) % N;
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one multi-cycle unsigned divider among NUM_REQ requesters, round-robin.
// Define DIV_SHARE_ARBITER_TIMEOUT_EN to bound the divider busy phase with TIMEOUT_CYCLES.
module div_share_arbiter
  import div_share_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*DIV_W-1:0] req_dividend,
  input  logic [NUM_REQ*DIV_W-1:0] req_divisor,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic [DIV_W-1:0]         resp_quotient,
  output logic [DIV_W-1:0]         resp_remainder,
  output logic                     resp_dbz,
  output logic                     resp_err,
  output logic                     div_start,
  output logic [DIV_W-1:0]         div_dividend,
  output logic [DIV_W-1:0]         div_divisor,
  input  logic [DIV_W-1:0]         div_quotient,
  input  logic [DIV_W-1:0]         div_remainder,
  input  logic                     div_done
);

  logic [DIV_W-1:0] dividend_arr [NUM_REQ];
  logic [DIV_W-1:0] divisor_arr  [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign dividend_arr[gi] = req_dividend[DIV_W*gi +: DIV_W];
      assign divisor_arr[gi]  = req_divisor[DIV_W*gi +: DIV_W];
    end
  endgenerate

  arb_state_e       state_reg;
  logic [ID_W-1:0]  rr_ptr_reg;
  logic [DIV_W-1:0] op_dividend_reg;
  logic [DIV_W-1:0] op_divisor_reg;
  logic             div_start_reg;
  logic             resp_valid_reg;
  resp_t            resp_reg;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    win_idx;
  logic               any_req;
  logic [DIV_W-1:0]   win_dividend;
  logic [DIV_W-1:0]   win_divisor;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr_reg),
    .grant     (grant),
    .grant_idx (win_idx),
    .any_req   (any_req)
  );

  assign win_dividend = dividend_arr[win_idx];
  assign win_divisor  = divisor_arr[win_idx];

  // Grant is offered only while idle, so the accept happens in the pick cycle.
  assign req_ready = (state_reg == IDLE && !rst) ? grant : '0;

`ifdef DIV_SHARE_ARBITER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] wait_cnt_reg;
  logic [TMO_W-1:0] wait_cnt_next;
  assign wait_cnt_next = wait_cnt_reg + 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      rr_ptr_reg      <= '0;
      op_dividend_reg <= '0;
      op_divisor_reg  <= '0;
      div_start_reg   <= 1'b0;
      resp_valid_reg  <= 1'b0;
      resp_reg        <= '0;
`ifdef DIV_SHARE_ARBITER_TIMEOUT_EN
      wait_cnt_reg    <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            op_dividend_reg <= win_dividend;
            op_divisor_reg  <= win_divisor;
            resp_reg.id     <= MAX_ID_W'(win_idx);
            rr_ptr_reg      <= (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            if (win_divisor == '0) begin
              // Divide-by-zero is answered locally without touching the divider.
              resp_reg.quotient  <= DBZ_QUOTIENT;
              resp_reg.remainder <= win_dividend;
              resp_reg.dbz       <= 1'b1;
              resp_reg.err       <= 1'b0;
              resp_valid_reg     <= 1'b1;
              state_reg          <= RESP;
            end else begin
              div_start_reg <= 1'b1;
              state_reg     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          div_start_reg <= 1'b0;
          state_reg     <= WAIT;
`ifdef DIV_SHARE_ARBITER_TIMEOUT_EN
          wait_cnt_reg  <= '0;
`endif
        end
        WAIT: begin
          if (div_done) begin
            resp_reg.quotient  <= div_quotient;
            resp_reg.remainder <= div_remainder;
            resp_reg.dbz       <= 1'b0;
            resp_reg.err       <= 1'b0;
            resp_valid_reg     <= 1'b1;
            state_reg          <= RESP;
          end
`ifdef DIV_SHARE_ARBITER_TIMEOUT_EN
          else begin
            wait_cnt_reg <= wait_cnt_next;
            if (wait_cnt_next == TMO_W'(TIMEOUT_CYCLES)) begin
              resp_reg.quotient  <= '0;
              resp_reg.remainder <= '0;
              resp_reg.dbz       <= 1'b0;
              resp_reg.err       <= 1'b1;
              resp_valid_reg     <= 1'b1;
              state_reg          <= RESP;
            end
          end
`endif
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_reg <= 1'b0;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign div_start      = div_start_reg;
  assign div_dividend   = op_dividend_reg;
  assign div_divisor    = op_divisor_reg;
  assign resp_valid     = resp_valid_reg;
  assign resp_id        = ID_W'(resp_reg.id);
  assign resp_quotient  = resp_reg.quotient;
  assign resp_remainder = resp_reg.remainder;
  assign resp_dbz       = resp_reg.dbz;
  // Without the watchdog, err is only ever loaded with 0.
  assign resp_err       = resp_reg.err;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed self-checking bench for div_share_arbiter with a fixed-latency divider model.
module tb_div_share_arbiter;

`ifdef DIV_SHARE_ARBITER_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 64;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_dividend;
  logic [127:0] req_divisor;
  logic         resp_valid;
  logic         resp_ready;
  logic [1:0]   resp_id;
  logic [31:0]  resp_quotient;
  logic [31:0]  resp_remainder;
  logic         resp_dbz;
  logic         resp_err;
  logic         div_start;
  logic [31:0]  div_dividend;
  logic [31:0]  div_divisor;
  logic [31:0]  div_quotient = '0;
  logic [31:0]  div_remainder = '0;
  logic         div_done;
  logic         model_done = 1'b0;
  logic         stray_done;

  int checks = 0;
  int errors = 0;
  int start_count = 0;
  int div_delay = 16;
  bit model_en = 1'b1;
  int model_rem = 0;
  logic [31:0] model_a = '0;
  logic [31:0] model_b = '0;

  always #5 clk = ~clk;

  div_share_arbiter #(
    .NUM_REQ        (4),
    .ID_W           (2),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_dividend   (req_dividend),
    .req_divisor    (req_divisor),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_id        (resp_id),
    .resp_quotient  (resp_quotient),
    .resp_remainder (resp_remainder),
    .resp_dbz       (resp_dbz),
    .resp_err       (resp_err),
    .div_start      (div_start),
    .div_dividend   (div_dividend),
    .div_divisor    (div_divisor),
    .div_quotient   (div_quotient),
    .div_remainder  (div_remainder),
    .div_done       (div_done)
  );

  assign div_done = model_done | stray_done;

  // Divider model: done pulses div_delay cycles after the start cycle.
  always @(posedge clk) begin
    model_done <= 1'b0;
    if (div_start) start_count <= start_count + 1;
    if (!model_en) begin
      model_rem <= 0;
    end else if (div_start) begin
      model_a   <= div_dividend;
      model_b   <= div_divisor;
      model_rem <= div_delay - 1;
    end else if (model_rem == 1) begin
      model_rem     <= 0;
      model_done    <= 1'b1;
      div_quotient  <= (model_b != 0) ? model_a / model_b : 32'd0;
      div_remainder <= (model_b != 0) ? model_a % model_b : 32'd0;
    end else if (model_rem > 1) begin
      model_rem <= model_rem - 1;
    end
  end

  task automatic send_req(input int idx, input logic [31:0] a, input logic [31:0] b, output bit ok);
    ok = 1'b0;
    @(posedge clk); #1;
    req_dividend[32*idx +: 32] = a;
    req_divisor[32*idx +: 32]  = b;
    req_valid[idx]             = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready[idx]) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
  endtask

  // Returns the number of negedges after the handshake edge until resp_valid, 0 on expiry.
  task automatic wait_resp(input int max_cycles, output int lat);
    lat = 0;
    for (int i = 1; i <= max_cycles; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = i;
        break;
      end
    end
    $display("resp id=%0d q=%0h r=%0h dbz=%0b err=%0b lat=%0d", resp_id, resp_quotient, resp_remainder, resp_dbz, resp_err, lat);
  endtask

  task automatic release_resp();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %0h expected 0", req_ready); end
    checks++; if ({resp_valid, resp_dbz, resp_err, div_start} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %0b expected 0", {resp_valid, resp_dbz, resp_err, div_start}); end
    checks++; if ({resp_id, resp_quotient, resp_remainder} !== 66'b0) begin errors++; $display("FAIL reset_resp_data: got %0h expected 0", {resp_id, resp_quotient, resp_remainder}); end
    checks++; if ({div_dividend, div_divisor} !== 64'b0) begin errors++; $display("FAIL reset_div_ops: got %0h expected 0", {div_dividend, div_divisor}); end
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 4'h0;
  endtask

  task automatic test_single();
    bit ok;
    int lat;
    int starts;
    div_delay = 16;
    starts = start_count;
    send_req(0, 32'd100, 32'd7, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_grant: got no grant expected grant"); end
    wait_resp(40, lat);
    checks++; if (lat != 18) begin errors++; $display("FAIL single_latency: got %0d expected 18", lat); end
    checks++; if (resp_id !== 2'd0) begin errors++; $display("FAIL single_id: got %0d expected 0", resp_id); end
    checks++; if (resp_quotient !== 32'd14) begin errors++; $display("FAIL single_q: got %0d expected 14", resp_quotient); end
    checks++; if (resp_remainder !== 32'd2) begin errors++; $display("FAIL single_r: got %0d expected 2", resp_remainder); end
    checks++; if ({resp_dbz, resp_err} !== 2'b00) begin errors++; $display("FAIL single_flags: got %0b expected 00", {resp_dbz, resp_err}); end
    checks++; if (start_count - starts != 1) begin errors++; $display("FAIL single_starts: got %0d expected 1", start_count - starts); end
    release_resp();
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_release: got %0b expected 0", resp_valid); end
  endtask

  task automatic test_dbz();
    bit ok;
    int lat;
    int starts;
    starts = start_count;
    send_req(2, 32'd55, 32'd0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL dbz_grant: got no grant expected grant"); end
    wait_resp(10, lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL dbz_latency: got %0d expected 1", lat); end
    checks++; if ({resp_id, resp_quotient, resp_remainder, resp_dbz} !== {2'd2, 32'hFFFF_FFFF, 32'd55, 1'b1}) begin
      errors++; $display("FAIL dbz_resp: got id=%0d q=%0h r=%0d dbz=%0b expected id=2 q=ffffffff r=55 dbz=1", resp_id, resp_quotient, resp_remainder, resp_dbz);
    end
    checks++; if (start_count != starts) begin errors++; $display("FAIL dbz_no_start: got %0d starts expected 0", start_count - starts); end
    release_resp();
  endtask

  task automatic test_round_robin();
    int lat;
    int order[5] = '{0, 1, 2, 3, 0};
    int exp_q[4] = '{333, 259, 214, 185};
    int exp_r[4] = '{1, 1, 4, 1};
    int id;
    rst = 1'b1;
    div_delay = 3;
    for (int i = 0; i < 4; i++) begin
      req_dividend[32*i +: 32] = 32'(1000 + 37 * i);
      req_divisor[32*i +: 32]  = 32'(i + 3);
    end
    req_valid = 4'hF;
    resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      id = order[k];
      wait_resp(30, lat);
      checks++;
      if (lat == 0) begin
        errors++; $display("FAIL rr_timeout_%0d: got no response expected id %0d", k, id);
      end else if ({resp_id, resp_quotient, resp_remainder} !== {2'(id), 32'(exp_q[id]), 32'(exp_r[id])}) begin
        errors++; $display("FAIL rr_resp_%0d: got id=%0d q=%0d r=%0d expected id=%0d q=%0d r=%0d", k, resp_id, resp_quotient, resp_remainder, id, exp_q[id], exp_r[id]);
      end
      @(posedge clk); #1;
      if (k == 4) req_valid = 4'h0;
    end
    resp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    int starts;
    div_delay = 3;
    send_req(3, 32'd90, 32'd9, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_grant: got no grant expected grant"); end
    req_dividend[32 +: 32] = 32'd77;
    req_divisor[32 +: 32]  = 32'd7;
    req_valid[1] = 1'b1;
    wait_resp(30, lat);
    starts = start_count;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({resp_valid, resp_id, resp_quotient, resp_remainder, req_ready} !== {1'b1, 2'd3, 32'd10, 32'd0, 4'b0}) begin
        errors++; $display("FAIL bp_hold_%0d: got v=%0b id=%0d q=%0d r=%0d rdy=%0h expected v=1 id=3 q=10 r=0 rdy=0", i, resp_valid, resp_id, resp_quotient, resp_remainder, req_ready);
      end
    end
    checks++; if (start_count != starts) begin errors++; $display("FAIL bp_no_start: got %0d starts expected 0", start_count - starts); end
    resp_ready = 1'b1;
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL bp_handshake_ready: got %0h expected 0", req_ready); end
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    checks++; if ({resp_valid, req_ready} !== {1'b0, 4'b0010}) begin errors++; $display("FAIL bp_next_grant: got v=%0b rdy=%0h expected v=0 rdy=2", resp_valid, req_ready); end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_resp(30, lat);
    checks++; if (lat != 5) begin errors++; $display("FAIL bp_next_latency: got %0d expected 5", lat); end
    checks++; if ({resp_id, resp_quotient, resp_remainder} !== {2'd1, 32'd11, 32'd0}) begin
      errors++; $display("FAIL bp_next_resp: got id=%0d q=%0d r=%0d expected id=1 q=11 r=0", resp_id, resp_quotient, resp_remainder);
    end
    release_resp();
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    bit seen;
    int lat;
    div_delay = 16;
    send_req(2, 32'd500, 32'd10, ok);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (div_start) begin
        seen = 1'b1;
        break;
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL rst_wait_start: got no div_start expected pulse"); end
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({resp_valid, div_start, req_ready, div_dividend, div_divisor} !== 70'b0) begin
      errors++; $display("FAIL rst_wait_outputs: got v=%0b st=%0b rdy=%0h a=%0d b=%0d expected all 0", resp_valid, div_start, req_ready, div_dividend, div_divisor);
    end
    @(posedge clk); #1 stray_done = 1'b1;
    @(posedge clk); #1 stray_done = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (resp_valid || div_start) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL rst_wait_stray: got activity after reset expected none"); end
    send_req(0, 32'd64, 32'd8, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_wait_regrant: got no grant expected grant"); end
    wait_resp(40, lat);
    checks++; if (lat != 18) begin errors++; $display("FAIL rst_wait_latency: got %0d expected 18", lat); end
    checks++; if ({resp_id, resp_quotient, resp_remainder, resp_dbz} !== {2'd0, 32'd8, 32'd0, 1'b0}) begin
      errors++; $display("FAIL rst_wait_resp: got id=%0d q=%0d r=%0d dbz=%0b expected id=0 q=8 r=0 dbz=0", resp_id, resp_quotient, resp_remainder, resp_dbz);
    end
    release_resp();
  endtask

`ifdef DIV_SHARE_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int lat;
    model_en = 1'b0;
    send_req(1, 32'd9, 32'd3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tmo_grant: got no grant expected grant"); end
    wait_resp(30, lat);
    checks++; if (lat != 10) begin errors++; $display("FAIL tmo_latency: got %0d expected 10", lat); end
    checks++; if ({resp_id, resp_quotient, resp_remainder, resp_dbz, resp_err} !== {2'd1, 32'd0, 32'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL tmo_resp: got id=%0d q=%0d r=%0d dbz=%0b err=%0b expected id=1 q=0 r=0 dbz=0 err=1", resp_id, resp_quotient, resp_remainder, resp_dbz, resp_err);
    end
    div_quotient = 32'd3;
    @(posedge clk); #1 stray_done = 1'b1;
    @(posedge clk); #1 stray_done = 1'b0;
    @(negedge clk);
    checks++; if ({resp_valid, resp_quotient, resp_err} !== {1'b1, 32'd0, 1'b1}) begin
      errors++; $display("FAIL tmo_late_done: got v=%0b q=%0d err=%0b expected v=1 q=0 err=1", resp_valid, resp_quotient, resp_err);
    end
    release_resp();
    model_en = 1'b1;
  endtask
`endif

  initial begin
    rst          = 1'b1;
    req_valid    = 4'h0;
    req_dividend = '0;
    req_divisor  = '0;
    resp_ready   = 1'b0;
    stray_done   = 1'b0;
    test_reset();
    test_single();
    test_dbz();
    test_round_robin();
    test_backpressure();
    test_reset_mid_wait();
`ifdef DIV_SHARE_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule
